spi_sclk_gen: RTL and testbench
===============================

SPI_SCLK_GEN -- requirements
Module: spi_sclk_gen

Interface
REQ-001 SHALL have parameter DIV_W, default 8, width of the half-period divider.
REQ-002 SHALL have parameter CNT_W, default 5, width of the bit-length field.
REQ-003 SHALL have port clk_i  input  1  system clock; all logic on its rising edge.
REQ-004 SHALL have port arst_n_i  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port en_i  input  1  block enable; low aborts any transfer.
REQ-006 SHALL have port start_i  input  1  transfer request.
REQ-007 SHALL have port div_i  input  DIV_W  half-period = div_i+1 clk_i cycles.
REQ-008 SHALL have port len_i  input  CNT_W  bits per transfer = len_i+1.
REQ-009 SHALL have ports cpol_i and cpha_i  input  1 each  SPI mode.
REQ-010 SHALL have port sclk_o  output  1  registered SPI clock.
REQ-011 SHALL have ports shift_o and sample_o  output  1 each  one-cycle data strobes.
REQ-012 SHALL have ports busy_o and done_o  output  1 each  transfer status, completion pulse.

Function
REQ-013 SHALL implement states IDLE, RUN and END.
REQ-014 In IDLE, sclk_o SHALL follow cpol_i with one cycle of latency.
REQ-015 start_i SHALL be accepted only when en_i=1 and state=IDLE, including the done_o cycle; otherwise it SHALL be ignored.
REQ-016 On acceptance in cycle T0, div_i, len_i, cpol_i and cpha_i SHALL be latched; later input changes SHALL NOT affect the transfer.
REQ-017 At T1 the block SHALL enter RUN with busy_o=1; with cpha=0, shift_o SHALL pulse at T1.
REQ-018 In RUN, sclk_o SHALL toggle at T1+k*(div+1) for k=1..2N, where N=len+1; div=0 gives clk_i/2.
REQ-019 Odd k are leading edges and even k are trailing edges.
REQ-020 cpha=0: sample_o SHALL pulse on leading edges; shift_o SHALL pulse on trailing edges except k=2N.
REQ-021 cpha=1: shift_o SHALL pulse on leading edges; sample_o SHALL pulse on trailing edges.
REQ-022 Strobes SHALL be asserted in the same cycle that sclk_o takes its new value.
REQ-023 After edge 2N, sclk_o SHALL equal the latched cpol, and the block SHALL enter END for div+1 cycles.
REQ-024 At T1+(2N+1)(div+1), the block SHALL return to IDLE, done_o SHALL pulse for one cycle, and busy_o SHALL be 0 in that cycle.
REQ-025 Each transfer SHALL produce exactly N sample_o pulses and exactly N shift_o pulses.
REQ-026 The half-period counter SHALL be DIV_W bits and the edge counter CNT_W+1 bits; neither SHALL wrap within a transfer.
REQ-027 If en_i=0 in RUN or END, the next cycle SHALL be IDLE with sclk_o=cpol_i, busy_o=0, no done_o and no strobes.

Reset
REQ-028 While arst_n_i=0, the block SHALL be in IDLE with sclk_o=0, shift_o=0, sample_o=0, busy_o=0, done_o=0 and all counters 0, regardless of clk_i.
REQ-029 Reset asserted mid-transfer SHALL abort immediately; no done_o SHALL follow.

Configuration
REQ-030 With macro SPI_SCLK_GEN_CS_EN defined, the block SHALL add output port cs_n_o (1 bit).
REQ-031 cs_n_o SHALL reset to 1, go 0 at T1, return to 1 in the done_o cycle, and return to 1 the cycle after an en_i abort.
REQ-032 Without SPI_SCLK_GEN_CS_EN, cs_n_o SHALL be absent and all other behaviour SHALL be unchanged.

Structure
REQ-033 Package spi_sclk_pkg SHALL hold the state encoding (IDLE, RUN, END), the default DIV_W/CNT_W constants and the edge-parity helper constants.
REQ-034 The half-period divider SHALL be sub-module spi_half_div (load, count, terminal-count pulse), instantiated once.
REQ-035 The FSM, edge counter and strobe logic SHALL reside in spi_sclk_gen.

Verification
REQ-036 Mode 0, div=0, len=7: sclk_o toggles every cycle for 16 edges; 8 sample_o on rising edges; shift_o at T1 plus 7 falling edges; done_o at T1+17.
REQ-037 Mode 3 (cpol=1, cpha=1), div=3, len=0: sclk_o idles high; falls at T1+4, rises at T1+8; shift_o at T1+4, sample_o at T1+8; done_o at T1+12.
REQ-038 start_i held high through a transfer, with len_i/div_i changed mid-transfer: no restart and timing unchanged; a new transfer begins at the done_o cycle.
REQ-039 en_i dropped at edge 5 of a len=3 transfer: busy_o=0 next cycle, sclk_o=cpol, no done_o, no further strobes.
REQ-040 arst_n_i pulsed low mid-RUN between clk_i edges: all outputs 0 immediately; the next start_i gives a normal transfer.
REQ-041 With SPI_SCLK_GEN_CS_EN, div=1, len=1: cs_n_o low from T1 through T1+9, high at T1+10 together with done_o.

Source files
------------

// File: rtl/spi_sclk_pkg.sv
// ---------------------------------------------------------------------------
// spi_sclk_pkg: shared state encoding and defaults for the SPI clock generator.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package spi_sclk_pkg;

    localparam int DEF_DIV_W = 8;
    localparam int DEF_CNT_W = 5;

    // The edge counter holds k-1, so an even count means the next edge is leading.
    localparam logic LEAD_PARITY  = 1'b0;
    localparam logic TRAIL_PARITY = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        END  = 2'd2
    } state_e;

endpackage

`default_nettype wire

// File: rtl/spi_half_div.sv
// ---------------------------------------------------------------------------
// spi_half_div: reloadable half-period down-counter with a terminal-count pulse.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module spi_half_div
    import spi_sclk_pkg::*;
#(
    parameter int DIV_W = DEF_DIV_W
) (
    input  logic             clk_i,
    input  logic             arst_n_i,
    input  logic             load_i,
    input  logic             run_i,
    input  logic [DIV_W-1:0] div_i,
    output logic             tc_o
);

    localparam logic [DIV_W-1:0] ONE = DIV_W'(1);

    logic [DIV_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = div_i;
        end else if (run_i) begin
            cnt_d = (cnt_q == '0) ? div_i : (cnt_q - ONE);
        end
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = run_i && !load_i && (cnt_q == '0);

endmodule

`default_nettype wire

// File: rtl/spi_sclk_gen.sv
// ---------------------------------------------------------------------------
// spi_sclk_gen: SPI serial clock and shift/sample strobe generator.
// Optional chip select output cs_n_o enabled by macro SPI_SCLK_GEN_CS_EN.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module spi_sclk_gen
    import spi_sclk_pkg::*;
#(
    parameter int DIV_W = DEF_DIV_W,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk_i,
    input  logic             arst_n_i,
    input  logic             en_i,
    input  logic             start_i,
    input  logic [DIV_W-1:0] div_i,
    input  logic [CNT_W-1:0] len_i,
    input  logic             cpol_i,
    input  logic             cpha_i,
    output logic             sclk_o,
    output logic             shift_o,
    output logic             sample_o,
    output logic             busy_o,
    output logic             done_o
`ifdef SPI_SCLK_GEN_CS_EN
    ,
    output logic             cs_n_o
`endif
);

    localparam logic [CNT_W:0] EDGE_ONE = (CNT_W + 1)'(1);

    state_e           state_q, state_d;
    logic             sclk_q, sclk_d;
    logic             shift_q, shift_d;
    logic             sample_q, sample_d;
    logic             done_q, done_d;
    logic [CNT_W:0]   edge_q, edge_d;
    logic [DIV_W-1:0] div_q;
    logic [CNT_W-1:0] len_q;
    logic             cpol_q, cpha_q;

    logic             accept;
    logic             tc;
    logic             last_edge;
    logic             lead_edge;
    logic             trail_edge;

    assign accept     = (state_q == IDLE) && en_i && start_i;
    assign last_edge  = (edge_q == {len_q, 1'b1});
    assign lead_edge  = (edge_q[0] == LEAD_PARITY);
    assign trail_edge = (edge_q[0] == TRAIL_PARITY);

    spi_half_div #(
        .DIV_W (DIV_W)
    ) u_half_div (
        .clk_i    (clk_i),
        .arst_n_i (arst_n_i),
        .load_i   (accept),
        .run_i    (state_q != IDLE),
        .div_i    (accept ? div_i : div_q),
        .tc_o     (tc)
    );

    always_comb begin
        state_d  = state_q;
        sclk_d   = sclk_q;
        shift_d  = 1'b0;
        sample_d = 1'b0;
        done_d   = 1'b0;
        edge_d   = edge_q;
        case (state_q)
            IDLE: begin
                sclk_d = cpol_i;
                edge_d = '0;
                if (accept) begin
                    state_d = RUN;
                    shift_d = !cpha_i;
                end
            end
            RUN: begin
                if (!en_i) begin
                    state_d = IDLE;
                    sclk_d  = cpol_i;
                end else if (tc) begin
                    sclk_d   = !sclk_q;
                    edge_d   = edge_q + EDGE_ONE;
                    sample_d = lead_edge ? !cpha_q : cpha_q;
                    shift_d  = lead_edge ? cpha_q : (trail_edge && !cpha_q && !last_edge);
                    if (last_edge) begin
                        state_d = END;
                        edge_d  = '0;
                    end
                end
            end
            END: begin
                if (!en_i) begin
                    state_d = IDLE;
                    sclk_d  = cpol_i;
                end else if (tc) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            state_q  <= IDLE;
            sclk_q   <= 1'b0;
            shift_q  <= 1'b0;
            sample_q <= 1'b0;
            done_q   <= 1'b0;
            edge_q   <= '0;
            div_q    <= '0;
            len_q    <= '0;
            cpol_q   <= 1'b0;
            cpha_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            sclk_q   <= sclk_d;
            shift_q  <= shift_d;
            sample_q <= sample_d;
            done_q   <= done_d;
            edge_q   <= edge_d;
            if (accept) begin
                div_q  <= div_i;
                len_q  <= len_i;
                cpol_q <= cpol_i;
                cpha_q <= cpha_i;
            end
        end
    end

`ifdef SPI_SCLK_GEN_CS_EN
    logic cs_n_q;

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            cs_n_q <= 1'b1;
        end else begin
            cs_n_q <= (state_d == IDLE);
        end
    end

    assign cs_n_o = cs_n_q;
`endif

    assign sclk_o   = sclk_q;
    assign shift_o  = shift_q;
    assign sample_o = sample_q;
    assign busy_o   = (state_q != IDLE);
    assign done_o   = done_q;

endmodule

`default_nettype wire

// File: tb/tb_spi_sclk_gen.sv
// ---------------------------------------------------------------------------
// tb_spi_sclk_gen: directed self-checking bench for spi_sclk_gen.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_spi_sclk_gen;

    localparam int DIV_W = 8;
    localparam int CNT_W = 5;

    logic             clk_i = 1'b0;
    logic             arst_n_i;
    logic             en_i;
    logic             start_i;
    logic [DIV_W-1:0] div_i;
    logic [CNT_W-1:0] len_i;
    logic             cpol_i;
    logic             cpha_i;
    logic             sclk_o;
    logic             shift_o;
    logic             sample_o;
    logic             busy_o;
    logic             done_o;
`ifdef SPI_SCLK_GEN_CS_EN
    logic             cs_n_o;
`endif

    int n_checks = 0;
    int n_errors = 0;

    spi_sclk_gen #(
        .DIV_W (DIV_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk_i    (clk_i),
        .arst_n_i (arst_n_i),
        .en_i     (en_i),
        .start_i  (start_i),
        .div_i    (div_i),
        .len_i    (len_i),
        .cpol_i   (cpol_i),
        .cpha_i   (cpha_i),
        .sclk_o   (sclk_o),
        .shift_o  (shift_o),
        .sample_o (sample_o),
        .busy_o   (busy_o),
        .done_o   (done_o)
`ifdef SPI_SCLK_GEN_CS_EN
        ,
        .cs_n_o   (cs_n_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_busy"},   int'(busy_o),   0);
        chk({tag, "_done"},   int'(done_o),   0);
        chk({tag, "_shift"},  int'(shift_o),  0);
        chk({tag, "_sample"}, int'(sample_o), 0);
    endtask

    // Drives one transfer from T0 and checks every cycle up to the done_o cycle
    // against the edge schedule: edge k lands d = k*(div+1) cycles after T1.
    task automatic run_xfer(input logic pol, input logic pha, input int dv,
                            input int ln, input bit hold);
        int n2;
        int hp;
        int last;
        int ns;
        int nsh;
        n2   = 2 * (ln + 1);
        hp   = dv + 1;
        last = (n2 + 1) * hp;
        ns   = 0;
        nsh  = 0;
        cpol_i  = pol;
        cpha_i  = pha;
        div_i   = DIV_W'(dv);
        len_i   = CNT_W'(ln);
        start_i = 1'b1;
        tick();
        if (hold) begin
            div_i  = ~div_i;
            len_i  = ~len_i;
            cpol_i = ~pol;
            cpha_i = ~pha;
        end else begin
            start_i = 1'b0;
        end
        for (int d = 0; d <= last; d++) begin
            int  e;
            int  ec;
            bit  at_edge;
            bit  exp_samp;
            bit  exp_shift;
            e       = d / hp;
            at_edge = (d % hp == 0) && (e >= 1) && (e <= n2);
            ec      = (e > n2) ? n2 : e;
            exp_samp  = at_edge && (pha ? (e % 2 == 0) : (e % 2 == 1));
            exp_shift = ((d == 0) && !pha) ||
                        (at_edge && (pha ? (e % 2 == 1) : ((e % 2 == 0) && (e != n2))));
            chk("sclk",   int'(sclk_o),   int'(pol) ^ (ec % 2));
            chk("sample", int'(sample_o), int'(exp_samp));
            chk("shift",  int'(shift_o),  int'(exp_shift));
            chk("busy",   int'(busy_o),   (d < last) ? 1 : 0);
            chk("done",   int'(done_o),   (d == last) ? 1 : 0);
`ifdef SPI_SCLK_GEN_CS_EN
            chk("cs_n",   int'(cs_n_o),   (d < last) ? 0 : 1);
`endif
            ns  += int'(sample_o);
            nsh += int'(shift_o);
            if (d < last) tick();
        end
        chk("n_sample", ns,  ln + 1);
        chk("n_shift",  nsh, ln + 1);
    endtask

    initial begin
        arst_n_i = 1'b0;
        en_i     = 1'b1;
        start_i  = 1'b0;
        div_i    = '0;
        len_i    = '0;
        cpol_i   = 1'b1;
        cpha_i   = 1'b0;

        // Reset held across clock edges keeps every output low.
        #12;
        chk("rst_sclk", int'(sclk_o), 0);
        chk_quiet("rst");
`ifdef SPI_SCLK_GEN_CS_EN
        chk("rst_cs_n", int'(cs_n_o), 1);
`endif
        arst_n_i = 1'b1;

        // Idle clock follows cpol_i one cycle later.
        tick();
        chk("idle_sclk_hi", int'(sclk_o), 1);
        cpol_i = 1'b0;
        chk("idle_sclk_lag", int'(sclk_o), 1);
        tick();
        chk("idle_sclk_lo", int'(sclk_o), 0);

        // start_i ignored while disabled.
        en_i    = 1'b0;
        start_i = 1'b1;
        tick();
        tick();
        chk_quiet("dis_start");
        start_i = 1'b0;
        en_i    = 1'b1;
        tick();

        run_xfer(1'b0, 1'b0, 0, 7, 1'b0);   // mode 0, fastest clock, 8 bits
        tick();
        run_xfer(1'b1, 1'b1, 3, 0, 1'b0);   // mode 3, one bit
        tick();
        run_xfer(1'b0, 1'b1, 2, 2, 1'b0);   // mode 1
        run_xfer(1'b1, 1'b0, 1, 3, 1'b0);   // mode 2, back-to-back from done cycle
        tick();
        run_xfer(1'b0, 1'b0, 1, 1, 1'b0);   // short transfer, div=1 len=1

        // start_i held with inputs scrambled mid-transfer; restart from done cycle.
        tick();
        run_xfer(1'b0, 1'b0, 2, 1, 1'b1);
        tick();
        chk("hold_restart_busy", int'(busy_o), 1);
        chk("hold_restart_done", int'(done_o), 0);
        start_i = 1'b0;
        en_i    = 1'b0;
        tick();
        chk_quiet("hold_abort");
        en_i = 1'b1;
        tick();

        // Abort on edge 5 of a len=3 transfer.
        cpol_i  = 1'b0;
        cpha_i  = 1'b0;
        div_i   = DIV_W'(1);
        len_i   = CNT_W'(3);
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        repeat (10) tick();
        chk("abort_edge5_sclk",   int'(sclk_o),   1);
        chk("abort_edge5_sample", int'(sample_o), 1);
        chk("abort_edge5_busy",   int'(busy_o),   1);
        en_i = 1'b0;
        tick();
        chk("abort_sclk", int'(sclk_o), 0);
        chk_quiet("abort");
`ifdef SPI_SCLK_GEN_CS_EN
        chk("abort_cs_n", int'(cs_n_o), 1);
`endif
        en_i = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk_quiet("post_abort");
        end

        // Asynchronous reset between clock edges in the middle of RUN.
        cpol_i  = 1'b1;
        cpha_i  = 1'b0;
        div_i   = DIV_W'(2);
        len_i   = CNT_W'(1);
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        repeat (7) tick();
        chk("arst_pre_sclk", int'(sclk_o), 1);
        chk("arst_pre_busy", int'(busy_o), 1);
        #3;
        arst_n_i = 1'b0;
        #1;
        chk("arst_sclk", int'(sclk_o), 0);
        chk_quiet("arst");
`ifdef SPI_SCLK_GEN_CS_EN
        chk("arst_cs_n", int'(cs_n_o), 1);
`endif
        #2;
        arst_n_i = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            chk_quiet("post_arst");
        end
        run_xfer(1'b0, 1'b0, 1, 2, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
